// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// hazard_pkg : opcode/ALU-op constants, FSM state type, field extractors
// Rev 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_JR    = 5'b00100;

  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  function automatic logic [4:0] f_opcode(input logic [31:0] inst);
    return inst[31:27];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] inst);
    return inst[26:22];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] inst);
    return inst[21:17];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] inst);
    return inst[16:12];
  endfunction

  function automatic logic [4:0] f_aluop(input logic [31:0] inst);
    return inst[6:2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
// ============================================================================
// pipeline_hazard_ctrl_if : latch contents in, stall/nop/multdiv controls out
// Rev 1.0
// ============================================================================
`default_nettype none

interface pipeline_hazard_ctrl_if;
  logic [31:0] inst_fd;
  logic [31:0] inst_dx;
  logic        branch_taken;
  logic        md_ready;
  logic        stall_pc;
  logic        stall_fd;
  logic        stall_dx;
  logic        nop_dx;
  logic        flush_fd;
  logic        nop_xm;
  logic        md_start;
  logic        md_busy;
  logic        md_timeout;

  modport master (
    output inst_fd, inst_dx, branch_taken, md_ready,
    input  stall_pc, stall_fd, stall_dx, nop_dx, flush_fd, nop_xm,
           md_start, md_busy, md_timeout
  );

  modport slave (
    input  inst_fd, inst_dx, branch_taken, md_ready,
    output stall_pc, stall_fd, stall_dx, nop_dx, flush_fd, nop_xm,
           md_start, md_busy, md_timeout
  );
endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_reg_use_decode.sv
// ============================================================================
// reg_use_decode : which registers the F/D instruction reads (sw data excluded)
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_use_decode
  import hazard_pkg::*;
(
  input  logic [31:0] inst_fd,
  output logic        rs_en,
  output logic [4:0]  rs,
  output logic        rt_en,
  output logic [4:0]  rt,
  output logic        rd_en,
  output logic [4:0]  rd
);

  logic [4:0] w_op;
  logic       unused_low;

  assign unused_low = ^inst_fd[11:0];

  always_comb begin
    w_op  = f_opcode(inst_fd);
    rs    = f_rs(inst_fd);
    rt    = f_rt(inst_fd);
    rd    = f_rd(inst_fd);
    rs_en = (w_op == OP_RTYPE) || (w_op == OP_ADDI) || (w_op == OP_LW) ||
            (w_op == OP_SW)    || (w_op == OP_BNE)  || (w_op == OP_BLT);
    rt_en = (w_op == OP_RTYPE);
    // sw's rd is store data; the memory-data bypass already covers it
    rd_en = (w_op == OP_BNE) || (w_op == OP_BLT) || (w_op == OP_JR);
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl : load-use / multdiv stall and branch flush scheduler
// Optional macro HAZARD_PERF_CNT_EN adds the stall_cycles counter port.
// Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_TIMEOUT = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int              CNT_W      = $clog2(MD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  logic       w_rs_en, w_rt_en, w_rd_en;
  logic [4:0] w_rs, w_rt, w_rd;
  logic [4:0] w_dx_op, w_dx_rd, w_dx_alu;
  logic       w_dx_md, w_load_use;
  logic       unused_dx;

  logic w_stall_pc, w_stall_fd, w_stall_dx, w_nop_dx, w_flush_fd, w_nop_xm;
  logic w_md_start, w_md_busy, w_md_timeout;

  reg_use_decode u_decode (
    .inst_fd (bus.inst_fd),
    .rs_en   (w_rs_en),
    .rs      (w_rs),
    .rt_en   (w_rt_en),
    .rt      (w_rt),
    .rd_en   (w_rd_en),
    .rd      (w_rd)
  );

  assign unused_dx = ^{bus.inst_dx[21:7], bus.inst_dx[1:0]};

  always_comb begin
    w_dx_op    = f_opcode(bus.inst_dx);
    w_dx_rd    = f_rd(bus.inst_dx);
    w_dx_alu   = f_aluop(bus.inst_dx);
    w_dx_md    = (w_dx_op == OP_RTYPE) &&
                 ((w_dx_alu == ALU_MUL) || (w_dx_alu == ALU_DIV));
    w_load_use = (w_dx_op == OP_LW) && (w_dx_rd != 5'd0) &&
                 ((w_rs_en && (w_rs == w_dx_rd)) ||
                  (w_rt_en && (w_rt == w_dx_rd)) ||
                  (w_rd_en && (w_rd == w_dx_rd)));
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_stall_pc   = 1'b0;
    w_stall_fd   = 1'b0;
    w_stall_dx   = 1'b0;
    w_nop_dx     = 1'b0;
    w_flush_fd   = 1'b0;
    w_nop_xm     = 1'b0;
    w_md_start   = 1'b0;
    w_md_busy    = 1'b0;
    w_md_timeout = 1'b0;
    // Outputs are gated by reset so an asserted reset releases every stall at once
    if (reset) begin
      case (r_state)
        RUN: begin
          if (bus.branch_taken) begin
            w_flush_fd = 1'b1;
            w_nop_dx   = 1'b1;
          end else if (w_dx_md) begin
            w_md_start   = 1'b1;
            w_stall_pc   = 1'b1;
            w_stall_fd   = 1'b1;
            w_stall_dx   = 1'b1;
            w_nop_xm     = 1'b1;
            w_cnt_next   = '0;
            w_state_next = MD_WAIT;
          end else if (w_load_use) begin
            w_stall_pc = 1'b1;
            w_stall_fd = 1'b1;
            w_nop_dx   = 1'b1;
          end
        end
        MD_WAIT: begin
          w_md_busy = 1'b1;
          if (bus.md_ready) begin
            w_state_next = RUN;
          end else if (r_cnt == C_CNT_LAST) begin
            w_md_timeout = 1'b1;
            w_nop_xm     = 1'b1;
            w_state_next = RUN;
          end else begin
            w_stall_pc = 1'b1;
            w_stall_fd = 1'b1;
            w_stall_dx = 1'b1;
            w_nop_xm   = 1'b1;
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        default: w_state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
    end else if (w_stall_pc && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

  assign bus.stall_pc   = w_stall_pc;
  assign bus.stall_fd   = w_stall_fd;
  assign bus.stall_dx   = w_stall_dx;
  assign bus.nop_dx     = w_nop_dx;
  assign bus.flush_fd   = w_flush_fd;
  assign bus.nop_xm     = w_nop_xm;
  assign bus.md_start   = w_md_start;
  assign bus.md_busy    = w_md_busy;
  assign bus.md_timeout = w_md_timeout;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// tb_pipeline_hazard_ctrl : directed + random stimulus, queue-based scoreboard
// Honours HAZARD_PERF_CNT_EN for the stall_cycles port.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int TO = 8;

  localparam logic [4:0] T_R    = 5'b00000;
  localparam logic [4:0] T_ADDI = 5'b00101;
  localparam logic [4:0] T_LW   = 5'b01000;
  localparam logic [4:0] T_SW   = 5'b00111;
  localparam logic [4:0] T_BNE  = 5'b00010;
  localparam logic [4:0] T_BLT  = 5'b00110;
  localparam logic [4:0] T_JR   = 5'b00100;
  localparam logic [4:0] T_MUL  = 5'b00110;
  localparam logic [4:0] T_DIV  = 5'b00111;

  typedef struct packed {
    logic        stall_pc;
    logic        stall_fd;
    logic        stall_dx;
    logic        nop_dx;
    logic        flush_fd;
    logic        nop_xm;
    logic        md_start;
    logic        md_busy;
    logic        md_timeout;
    logic [31:0] perf;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  pipeline_hazard_ctrl_if bus ();
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  pipeline_hazard_ctrl #(.MD_TIMEOUT(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  exp_t            exp_q[$];
  int              tests = 0;
  int              fails = 0;
  bit              stim_done = 1'b0;
  bit              m_wait = 1'b0;
  int              m_waited = 0;
  longint unsigned m_perf = 0;

  function automatic logic [31:0] mk(input logic [4:0] op, rd, rs, rt, alu);
    return {op, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  function automatic bit reads(input logic [31:0] fd, input logic [4:0] r);
    logic [4:0] op;
    bit hit;
    op  = fd[31:27];
    hit = 1'b0;
    if (r == 5'd0) return 1'b0;
    if ((op inside {T_R, T_ADDI, T_LW, T_SW, T_BNE, T_BLT}) && fd[21:17] == r) hit = 1'b1;
    if (op == T_R && fd[16:12] == r) hit = 1'b1;
    if ((op inside {T_BNE, T_BLT, T_JR}) && fd[26:22] == r) hit = 1'b1;
    return hit;
  endfunction

  function automatic bit is_md(input logic [31:0] dx);
    return dx[31:27] == T_R && (dx[6:2] == T_MUL || dx[6:2] == T_DIV);
  endfunction

  function automatic bit load_use(input logic [31:0] fd, input logic [31:0] dx);
    return dx[31:27] == T_LW && reads(fd, dx[26:22]);
  endfunction

  function automatic logic [31:0] rand_inst();
    int         k;
    logic [4:0] op;
    logic [4:0] alu;
    k = $urandom_range(0, 7);
    case (k)
      0: op = T_R;
      1: op = T_ADDI;
      2: op = T_LW;
      3: op = T_SW;
      4: op = T_BNE;
      5: op = T_BLT;
      6: op = T_JR;
      default: op = 5'($urandom);
    endcase
    if ($urandom_range(0, 2) == 0) alu = ($urandom_range(0, 1) == 1) ? T_MUL : T_DIV;
    else alu = 5'($urandom);
    return mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), alu);
  endfunction

  // One pipeline cycle: apply inputs, predict outputs, advance the model past the edge
  task automatic step(input logic [31:0] fd, input logic [31:0] dx,
                      input bit bt, input bit rdy, input bit rst);
    exp_t e;
    @(posedge clock);
    #1;
    bus.inst_fd      = fd;
    bus.inst_dx      = dx;
    bus.branch_taken = bt;
    bus.md_ready     = rdy;
    reset            = rst;
    e = '0;
    if (!rst) begin
      m_wait   = 1'b0;
      m_waited = 0;
      m_perf   = 0;
    end else if (!m_wait) begin
      if (bt) begin
        e.flush_fd = 1'b1;
        e.nop_dx   = 1'b1;
      end else if (is_md(dx)) begin
        e.md_start = 1'b1;
        e.stall_pc = 1'b1;
        e.stall_fd = 1'b1;
        e.stall_dx = 1'b1;
        e.nop_xm   = 1'b1;
      end else if (load_use(fd, dx)) begin
        e.stall_pc = 1'b1;
        e.stall_fd = 1'b1;
        e.nop_dx   = 1'b1;
      end
    end else begin
      e.md_busy = 1'b1;
      if (!rdy && m_waited + 1 < TO) begin
        e.stall_pc = 1'b1;
        e.stall_fd = 1'b1;
        e.stall_dx = 1'b1;
        e.nop_xm   = 1'b1;
      end else if (!rdy) begin
        e.md_timeout = 1'b1;
        e.nop_xm     = 1'b1;
      end
    end
`ifdef HAZARD_PERF_CNT_EN
    e.perf = m_perf[31:0];
`else
    e.perf = '0;
`endif
    exp_q.push_back(e);
    if (rst) begin
      if (e.md_start) begin
        m_wait   = 1'b1;
        m_waited = 0;
      end else if (m_wait) begin
        if (e.stall_pc) m_waited++;
        else m_wait = 1'b0;
      end
      if (e.stall_pc && m_perf < 64'hFFFF_FFFF) m_perf++;
    end
  endtask

  initial begin : monitor
    exp_t e;
    exp_t act;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act.stall_pc   = bus.stall_pc;
        act.stall_fd   = bus.stall_fd;
        act.stall_dx   = bus.stall_dx;
        act.nop_dx     = bus.nop_dx;
        act.flush_fd   = bus.flush_fd;
        act.nop_xm     = bus.nop_xm;
        act.md_start   = bus.md_start;
        act.md_busy    = bus.md_busy;
        act.md_timeout = bus.md_timeout;
`ifdef HAZARD_PERF_CNT_EN
        act.perf       = stall_cycles;
`else
        act.perf       = '0;
`endif
        tests++;
        if (act !== e) begin
          fails++;
          $display("FAIL ctrl_outputs @%0t fd=%h dx=%h: got flags=%b cnt=%0d, want flags=%b cnt=%0d",
                   $time, bus.inst_fd, bus.inst_dx, act[40:32], act.perf, e[40:32], e.perf);
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] dx;
    logic [31:0] mul_i;
    logic [31:0] div_i;
    bit          rst_b;
    bit          bt_b;
    bit          rdy_b;
    int          guard;
    mul_i = mk(T_R, 5'd6, 5'd1, 5'd2, T_MUL);
    div_i = mk(T_R, 5'd7, 5'd1, 5'd2, T_DIV);
    bus.inst_fd      = '0;
    bus.inst_dx      = '0;
    bus.branch_taken = 1'b0;
    bus.md_ready     = 1'b0;

    // Reset state with quiet inputs
    repeat (2) step('0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) step('0, '0, 1'b0, 1'b0, 1'b1);

    // lw r3 then add r4,r3,r5: one bubble, then clear
    step(mk(T_R, 5'd4, 5'd3, 5'd5, 5'd0), mk(T_LW, 5'd3, 5'd1, 5'd0, 5'd0), 1'b0, 1'b0, 1'b1);
    step(mk(T_R, 5'd4, 5'd3, 5'd5, 5'd0), '0, 1'b0, 1'b0, 1'b1);
    // lw r0 never matches
    step(mk(T_R, 5'd4, 5'd0, 5'd0, 5'd0), mk(T_LW, 5'd0, 5'd1, 5'd0, 5'd0), 1'b0, 1'b0, 1'b1);
    // sw store-data register is not a use; bne rd is
    step(mk(T_SW, 5'd3, 5'd1, 5'd0, 5'd0), mk(T_LW, 5'd3, 5'd1, 5'd0, 5'd0), 1'b0, 1'b0, 1'b1);
    step(mk(T_BNE, 5'd3, 5'd1, 5'd0, 5'd0), mk(T_LW, 5'd3, 5'd1, 5'd0, 5'd0), 1'b0, 1'b0, 1'b1);

    // mul, md_ready arrives 5 cycles after md_start
    step('0, mul_i, 1'b0, 1'b0, 1'b1);
    repeat (4) step('0, mul_i, 1'b0, 1'b0, 1'b1);
    step('0, mul_i, 1'b0, 1'b1, 1'b1);
    step('0, '0, 1'b0, 1'b0, 1'b1);

    // div that never completes: timeout on the 8th cycle after md_start
    step('0, div_i, 1'b0, 1'b0, 1'b1);
    repeat (TO) step('0, div_i, 1'b1, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b0, 1'b1);

    // branch wins over load-use
    step(mk(T_R, 5'd4, 5'd3, 5'd5, 5'd0), mk(T_LW, 5'd3, 5'd1, 5'd0, 5'd0), 1'b1, 1'b0, 1'b1);

    // reset 3 cycles into MD_WAIT, mul still in D/X
    step('0, mul_i, 1'b0, 1'b0, 1'b1);
    repeat (3) step('0, mul_i, 1'b0, 1'b0, 1'b1);
    step('0, mul_i, 1'b0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic; D/X holds its mul/div while the model is waiting
    dx = '0;
    for (int i = 0; i < 3000; i++) begin
      rst_b = ($urandom_range(0, 299) != 0);
      bt_b  = ($urandom_range(0, 7) == 0);
      rdy_b = ($urandom_range(0, 5) == 0);
      if (!m_wait) dx = rand_inst();
      step(rand_inst(), dx, bt_b, rdy_b, rst_b);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clock);
      guard++;
    end
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Stall/flush scheduler for the 5-stage pipeline, working next to the operand bypass network. Forwarding cannot cover two hazards: a load followed by an instruction that uses its result, and a multi-cycle multiply/divide. This block detects both, sequences the multdiv unit through a start/wait/commit handshake with a timeout, and squashes wrong-path instructions on a taken control transfer. It drives the PC, F/D, D/X and X/M latch enables and the nop-insert selects.

## Interface
Parameters:
- MD_TIMEOUT, 64, maximum wait cycles for multdiv ready; must be ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low
- inst_fd  in  32  instruction in F/D latch
- inst_dx  in  32  instruction in D/X latch
- branch_taken  in  1  control transfer resolved taken in X (bne/blt/j/jal/jr/bex)
- md_ready  in  1  multdiv result valid
- stall_pc  out  1  hold PC
- stall_fd  out  1  hold F/D latch
- stall_dx  out  1  hold D/X latch
- nop_dx  out  1  load nop into D/X
- flush_fd  out  1  load nop into F/D
- nop_xm  out  1  load nop into X/M
- md_start  out  1  one-cycle multdiv start pulse
- md_busy  out  1  high in MD_WAIT
- md_timeout  out  1  one-cycle pulse on abort
- stall_cycles  out  32  stall counter, present only with the macro in Configuration

## Operation
- Decode fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2].
- Opcodes:
  - R-type 00000; addi 00101; lw 01000; sw 00111
  - bne 00010; blt 00110; jr 00100
  - mul is R-type with ALU op 00110; div is R-type with ALU op 00111.
- Registers read by F/D:
  - rs for R-type/addi/lw/sw/bne/blt.
  - rt for R-type.
  - rd for bne/blt/jr. The rd of sw is excluded because the memory-data bypass covers it.
  - A read of r0 never matches.
- Load-use condition: D/X is lw, D/X rd ≠ 0, and D/X rd equals any register read by F/D.
- FSM states: RUN, MD_WAIT. A 7-bit (clog2(MD_TIMEOUT+1)) wait counter.
- RUN, evaluated in priority order:
  1. branch_taken: flush_fd=1, nop_dx=1, no stalls; stay in RUN.
  2. D/X is mul/div: md_start=1, stall_pc=stall_fd=stall_dx=1, nop_xm=1; counter←0; go to MD_WAIT.
  3. Load-use: stall_pc=stall_fd=1, nop_dx=1 for one cycle. The bubble removes the condition, so it self-terminates.
  4. Otherwise all outputs are 0.
- MD_WAIT (md_busy=1):
  - md_ready=1: no stall and no nop; D/X advances and commits the result; go to RUN.
  - Else if counter == MD_TIMEOUT−1: md_timeout=1, nop_xm=1 (result squashed), stalls released; go to RUN.
  - Else: stall_pc/fd/dx=1, nop_xm=1, counter+1.
  - md_ready wins over a timeout in the same cycle.
  - branch_taken is ignored, because D/X holds mul/div, not a branch.

## Timing
- All outputs are combinational from state, counter and inputs. The next state is registered on the rising edge of clock.
- Reset (reset=0) acts immediately and asynchronously: state=RUN, counter=0, stall_cycles=0. With inputs quiet, every output is 0.
- Reset asserted mid-MD_WAIT drops md_busy and all stalls in the same cycle. The multdiv unit is reset by the same signal.
- Load-use penalty: exactly 1 cycle.
- Multdiv penalty: the number of cycles from md_start up to, but not including, the md_ready cycle. Timeout penalty: MD_TIMEOUT cycles.
- md_start is high only on the RUN→MD_WAIT transition cycle and never re-fires for the same instruction.

## Configuration
- HAZARD_PERF_CNT_EN defined: the stall_cycles port exists.
  - It counts each cycle with stall_pc=1 and saturates at 2^32−1.
  - It resets to 0.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `hazard_pkg`:
  - opcode constants (R-type, addi, lw, sw, bne, blt, jr)
  - ALU op constants (mul, div)
  - state enum {RUN, MD_WAIT}
- One combinational sub-module, `reg_use_decode`: takes inst_fd and outputs the read-enable and register number for rs, rt and rd. The top level holds the FSM, the counter and the priority logic.

## Test plan
- D/X=lw r3, F/D=add r4,r3,r5 → 1 cycle of stall_pc=stall_fd=nop_dx=1, then 0.
- D/X=lw r0, F/D reads r0 → no stall.
- D/X=mul, md_ready rises 5 cycles after md_start → one md_start pulse, 5 stall cycles, nop_xm during the stalls, return to RUN; stall_cycles=5 with the macro defined.
- MD_TIMEOUT=8, md_ready held 0 → md_timeout pulse 8 cycles after md_start, nop_xm=1 in that cycle, 8 stall cycles total.
- branch_taken=1 while the load-use condition is true → flush_fd=nop_dx=1, stall_pc=0.
- reset pulsed low 3 cycles into MD_WAIT → md_busy=0 and stalls=0 immediately; after release, state=RUN and stall_cycles=0.
